spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI slave front end for the OZY GPIO register bank.
- Deserialises 16-bit SPI frames from the host into the strobe/address/data bus consumed by the 8-bit register instances: STB, 7-bit ADDR, 8-bit write data.
- Also supports read frames, returning one byte on MISO from a read-data mux supplied by the register bank.
- All SPI inputs are oversampled in the CLK domain; no SCK-clocked logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for SCK, MOSI, SS_N (minimum 2).

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-high
- SCK  input  1  SPI clock, mode 0, idle low
- SS_N  input  1  SPI select, active-low
- MOSI  input  1  SPI data in, MSB first
- MISO  output  1  SPI data out
- MISO_OE  output  1  high while MISO carries read data
- STB  output  1  one-cycle write strobe to the register bank
- ADDR  output  7  register address
- WDATA  output  8  write data to the register bank
- RD_STB  output  1  one-cycle read request
- RD_DATA  input  8  read data from the register-bank mux

Behaviour:
- Frame format, MSB first, 16 bits:
  - bit 15: R/W (1 = read)
  - bits 14:8: ADDR
  - bits 7:0: data (write payload, or don't-care on a read)
- Input synchronisation:
  - SCK, MOSI and SS_N each pass through SYNC_STAGES flops, plus one extra SCK flop for edge detection.
  - Edge detect: rise = sync & ~prev; fall = ~sync & prev.
- Host timing requirement: SCK high and low times each ≥ 4 CLK; SS_N setup/hold to SCK ≥ 4 CLK.
- Reset values: MISO=0, MISO_OE=0, STB=0, RD_STB=0, ADDR=0, WDATA=0, bit counter=0, state=WAIT_IDLE.
- States:
  - WAIT_IDLE: stays until synced SS_N=1, then goes to IDLE. Guarantees a frame already in progress at reset release is never decoded.
  - IDLE: synced SS_N=0 → HDR; counter cleared.
  - HDR: each SCK rise shifts MOSI into an 8-bit shift register and increments the counter. On the 8th rise:
    - ADDR loads shifter[6:0] on the following CLK.
    - If R/W=1: RD_STB pulses for exactly 1 CLK in that same cycle.
    - Go to DATA.
  - DATA:
    - Each SCK rise shifts MOSI.
    - Write frame, 16th rise: on the following CLK, WDATA loads shifter[7:0] and STB pulses for exactly 1 CLK in that same cycle. ADDR is stable during and after STB.
    - Read frame: RD_DATA is captured into the TX shifter 2 CLK after the RD_STB cycle; RD_DATA must be stable by then. MISO_OE=1.
      - First SCK fall after the 8th rise: MISO drives TX[7].
      - Each later fall: shifts the next bit out.
      - After the 16th rise: MISO_OE=0, MISO=0.
    - After the 16th rise → DONE.
  - DONE: ignores further SCK edges (frames longer than 16 bits are truncated, extra bits discarded); synced SS_N=1 → IDLE.
- Abort: synced SS_N rising in HDR or DATA → IDLE. No STB, WDATA unchanged, MISO_OE=0, MISO=0. ADDR may already have updated.
- ADDR and WDATA hold their values until overwritten; only a completed write frame updates WDATA.
- STB and RD_STB are never both high, and never high in consecutive cycles within one frame.
- Async RST asserted mid-frame: all outputs return to reset values immediately, then WAIT_IDLE.
- Latency: STB asserts SYNC_STAGES+2 CLK after the physical 16th SCK rise.

Test Plan:
- Write frame 0x05A5 (R/W=0, ADDR=0x05, data=0xA5), SCK = 8 CLK period → exactly one STB pulse with ADDR=0x05, WDATA=0xA5; RD_STB never asserts; MISO_OE stays 0.
- Read frame 0x9200 with RD_DATA=0x3C → one RD_STB pulse with ADDR=0x12; MISO at bits 9–16 reads 0,0,1,1,1,1,0,0; MISO_OE high only during those bits; STB never asserts.
- Write frame to ADDR 0x05 with data 0xA5, aborted by SS_N high after 10 SCKs → no STB; WDATA unchanged from its prior value; next full write 0x0711 → STB, ADDR=0x07, WDATA=0x11.
- 20-SCK write frame 0x0F5A followed by 4 extra bits of 1s → one STB with ADDR=0x0F, WDATA=0x5A; extra bits ignored.
- RST pulsed after 6 SCKs of a frame, SS_N still low → outputs reset; remaining SCKs produce no STB or RD_STB; a fresh frame after an SS_N high/low cycle decodes correctly.
- Back-to-back writes 0x0101 then 0x0202 with SS_N high for 4 CLK between → two STB pulses, (ADDR, WDATA) = (0x01, 0x01) then (0x02, 0x02).

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI slave front end for the OZY GPIO register bank.
// Oversamples SCK/MOSI/SS_N in the clk domain and decodes 16-bit read/write frames.
module spi_reg_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic       o_stb,
  output logic [6:0] o_addr,
  output logic [7:0] o_wdata,
  output logic       o_rd_stb,
  input  logic [7:0] i_rd_data
);

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned HDR_BITS   = 8;
  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sck_prev;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_rw;
  logic [DATA_W-1:0]   r_tx;
  logic                r_rd_d1;
  logic                r_miso;
  logic                r_miso_oe;
  logic                r_stb;
  logic                r_rd_stb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_rw_nxt;
  logic [DATA_W-1:0]   w_tx_nxt;
  logic                w_miso_nxt;
  logic                w_miso_oe_nxt;
  logic                w_stb_nxt;
  logic                w_rd_stb_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;

  logic w_sck;
  logic w_mosi;
  logic w_ss_n;
  logic w_rise;
  logic w_fall;

  // SS_N sync resets low so a frame already running at reset release keeps us in WAIT_IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1];
  assign w_rise = w_sck & ~r_sck_prev;
  assign w_fall = ~w_sck & r_sck_prev;

  // Frame decode: rises only shift/count, the boundary actions fire the cycle after
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_rw_nxt      = r_rw;
    w_tx_nxt      = r_tx;
    w_miso_nxt    = r_miso;
    w_miso_oe_nxt = r_miso_oe;
    w_stb_nxt     = 1'b0;
    w_rd_stb_nxt  = 1'b0;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;

    unique case (r_state)
      S_WAIT_IDLE: begin
        if (w_ss_n) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!w_ss_n) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = '0;
        end
      end
      S_HDR: begin
        if (w_ss_n) begin
          w_state_nxt   = S_IDLE;
          w_miso_nxt    = 1'b0;
          w_miso_oe_nxt = 1'b0;
        end else if (r_cnt == CNT_W'(HDR_BITS)) begin
          w_addr_nxt   = r_shift[ADDR_W-1:0];
          w_rw_nxt     = r_shift[DATA_W-1];
          w_rd_stb_nxt = r_shift[DATA_W-1];
          w_state_nxt  = S_DATA;
        end else if (w_rise) begin
          w_shift_nxt = {r_shift[DATA_W-2:0], w_mosi};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_ss_n) begin
          w_state_nxt   = S_IDLE;
          w_miso_nxt    = 1'b0;
          w_miso_oe_nxt = 1'b0;
        end else if (r_cnt == CNT_W'(FRAME_BITS)) begin
          if (!r_rw) begin
            w_wdata_nxt = r_shift;
            w_stb_nxt   = 1'b1;
          end
          w_miso_nxt    = 1'b0;
          w_miso_oe_nxt = 1'b0;
          w_state_nxt   = S_DONE;
        end else begin
          if (w_rise) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], w_mosi};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
          if (r_rw && r_rd_d1) begin
            w_tx_nxt      = i_rd_data;
            w_miso_oe_nxt = 1'b1;
          end else if (r_rw && w_fall) begin
            w_miso_nxt = r_tx[DATA_W-1];
            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        if (w_ss_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_WAIT_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_tx      <= '0;
      r_rd_d1   <= 1'b0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
      r_stb     <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rw      <= w_rw_nxt;
      r_tx      <= w_tx_nxt;
      r_rd_d1   <= r_rd_stb;
      r_miso    <= w_miso_nxt;
      r_miso_oe <= w_miso_oe_nxt;
      r_stb     <= w_stb_nxt;
      r_rd_stb  <= w_rd_stb_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  assign o_miso    = r_miso;
  assign o_miso_oe = r_miso_oe;
  assign o_stb     = r_stb;
  assign o_rd_stb  = r_rd_stb;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: bit-banged SPI host, strobe scoreboard and MISO/OE checks.
module tb_spi_reg_slave;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 4;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       stb;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       rd_stb;
  logic [7:0] rd_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc = 0;
  int unsigned cyc_rise16 = 0;
  int          stb_cnt = 0;
  int          rd_cnt  = 0;
  wr_exp_t     wr_q[$];
  logic [6:0]  rd_q[$];
  wr_exp_t     e_wr;
  logic [6:0]  e_rd;
  logic [7:0]  exp_wdata;

  spi_reg_slave #(.SYNC_STAGES(SYNC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sck     (sck),
    .i_ss_n    (ss_n),
    .i_mosi    (mosi),
    .o_miso    (miso),
    .o_miso_oe (miso_oe),
    .o_stb     (stb),
    .o_addr    (addr),
    .o_wdata   (wdata),
    .o_rd_stb  (rd_stb),
    .i_rd_data (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},    miso,    0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
    chk({tag, "_stb"},     stb,     0);
    chk({tag, "_rd_stb"},  rd_stb,  0);
    chk({tag, "_addr"},    addr,    0);
    chk({tag, "_wdata"},   wdata,   0);
  endtask

  // Strobe monitor: every pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (stb && rd_stb) chk("stb_rd_stb_overlap", 1, 0);
      if (stb) begin
        stb_cnt++;
        if (wr_q.size() == 0) chk("stb_unexpected", 1, 0);
        else begin
          e_wr = wr_q.pop_front();
          chk("stb_addr", addr, e_wr.addr);
          chk("stb_wdata", wdata, e_wr.data);
          chk("stb_latency", cyc - cyc_rise16, SYNC + 2);
        end
      end
      if (rd_stb) begin
        rd_cnt++;
        if (rd_q.size() == 0) chk("rd_stb_unexpected", 1, 0);
        else begin
          e_rd = rd_q.pop_front();
          chk("rd_stb_addr", addr, e_rd);
        end
      end
    end
  end

  // Host frame: nbits clocks (bits past 16 send 1s), optional reset pulse before bit rst_at
  task automatic frame(input logic [15:0] w, input int nbits, input bit is_read,
                       input logic [7:0] rdv, input int rst_at);
    ss_n = 1'b0;
    wait_clk(HALF);
    for (int i = 1; i <= nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(1);
        chk_reset_outputs("midframe_rst");
        rst = 1'b0;
        exp_wdata = 8'h00;
      end
      mosi = (i <= 16) ? w[16-i] : 1'b1;
      wait_clk(HALF);
      if (i <= 16 && rst_at == 0) begin
        chk("miso_oe_bit", miso_oe, (is_read && i >= 9) ? 1 : 0);
        if (is_read && i >= 9) chk("miso_bit", miso, rdv[16-i]);
      end
      sck = 1'b1;
      if (i == 16) cyc_rise16 = cyc;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    chk("miso_oe_end", miso_oe, 0);
    chk("miso_end", miso, 0);
    ss_n = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; rd_data = 8'h00;
    exp_wdata = 8'h00;
    wait_clk(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // Plain write
    s0 = stb_cnt; r0 = rd_cnt;
    exp_wr(7'h05, 8'hA5);
    frame(16'h05A5, 16, 1'b0, 8'h00, 0);
    exp_wdata = 8'hA5;
    chk("t1_stb_count", stb_cnt - s0, 1);
    chk("t1_rd_count", rd_cnt - r0, 0);

    // Read returning 0x3C
    s0 = stb_cnt; r0 = rd_cnt;
    rd_data = 8'h3C;
    rd_q.push_back(7'h12);
    frame(16'h9200, 16, 1'b1, 8'h3C, 0);
    chk("t2_stb_count", stb_cnt - s0, 0);
    chk("t2_rd_count", rd_cnt - r0, 1);
    chk("t2_wdata_hold", wdata, exp_wdata);

    // Aborted write, then a full write
    s0 = stb_cnt;
    frame(16'h05A5, 10, 1'b0, 8'h00, 0);
    chk("t3_abort_stb_count", stb_cnt - s0, 0);
    chk("t3_abort_wdata", wdata, exp_wdata);
    exp_wr(7'h07, 8'h11);
    frame(16'h0711, 16, 1'b0, 8'h00, 0);
    exp_wdata = 8'h11;
    chk("t3_stb_count", stb_cnt - s0, 1);

    // Overlong frame, extra bits ignored
    s0 = stb_cnt; r0 = rd_cnt;
    exp_wr(7'h0F, 8'h5A);
    frame(16'h0F5A, 20, 1'b0, 8'h00, 0);
    exp_wdata = 8'h5A;
    chk("t4_stb_count", stb_cnt - s0, 1);
    chk("t4_wdata", wdata, exp_wdata);
    chk("t4_addr", addr, 7'h0F);

    // Reset after 6 clocks with SS_N held low, then a fresh frame
    s0 = stb_cnt; r0 = rd_cnt;
    frame(16'h05A5, 16, 1'b0, 8'h00, 7);
    chk("t5_stb_count", stb_cnt - s0, 0);
    chk("t5_rd_count", rd_cnt - r0, 0);
    chk("t5_wdata", wdata, exp_wdata);
    exp_wr(7'h03, 8'hC3);
    frame(16'h03C3, 16, 1'b0, 8'h00, 0);
    exp_wdata = 8'hC3;
    chk("t5_fresh_stb_count", stb_cnt - s0, 1);

    // Back-to-back writes, SS_N high for HALF clocks between
    s0 = stb_cnt;
    exp_wr(7'h01, 8'h01);
    exp_wr(7'h02, 8'h02);
    frame(16'h0101, 16, 1'b0, 8'h00, 0);
    frame(16'h0202, 16, 1'b0, 8'h00, 0);
    exp_wdata = 8'h02;
    chk("t6_stb_count", stb_cnt - s0, 2);
    chk("t6_wdata", wdata, exp_wdata);
    chk("t6_addr", addr, 7'h02);

    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
